// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin command arbiter that shares one CCE-MEM link among several requesters.
// An issue-order ID tracker routes the in-order responses back to each originator.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p         = 4,
  parameter int msg_width_p       = 600,
  parameter int max_outstanding_p = 8,
  localparam int req_id_width_lp  = $clog2(num_req_p),
  localparam int count_width_lp   = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,

  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_ready_o,

  output logic [num_req_p*msg_width_p-1:0] req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_yumi_i,

  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,

  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,

  output logic [count_width_lp-1:0]        outstanding_o,
  output logic                             err_o
);

  localparam int ptr_width_lp = $clog2(max_outstanding_p);

  typedef logic [req_id_width_lp-1:0] req_id_t;
  typedef logic [ptr_width_lp-1:0]    ptr_t;
  typedef logic [count_width_lp-1:0]  count_t;

  localparam count_t  full_count_lp = count_t'(max_outstanding_p);
  localparam req_id_t last_reset_lp = req_id_t'(num_req_p - 1);

  req_id_t last_r, gnt_id_r, scan_id, grant, head_id;
  logic    lock_r, err_r, scan_found, full, empty, fire, pop;
  ptr_t    head_r, tail_r;
  count_t  count_r;
  int      scan_idx;
  req_id_t tracker_r [max_outstanding_p];

  // Rotating priority scan starting just after the last requester that issued.
  // NOTE: every variable driven here gets a default first, so no path leaves a latch.
  always_comb begin
    scan_id    = last_r;
    scan_found = 1'b0;
    scan_idx   = 0;
    for (int k = 1; k <= num_req_p; k++) begin
      scan_idx = (int'(last_r) + k) % num_req_p;
      if (!scan_found && req_cmd_v_i[scan_idx]) begin
        scan_id    = req_id_t'(scan_idx);
        scan_found = 1'b1;
      end
    end
  end

  // A stalled grant stays pinned until it fires, even if a higher-priority valid shows up.
  assign grant     = lock_r ? gnt_id_r : scan_id;
  assign full      = (count_r == full_count_lp);
  assign empty     = (count_r == '0);
  assign mem_cmd_v_o = reset_n_i & ~full
                     & (lock_r ? req_cmd_v_i[gnt_id_r] : (|req_cmd_v_i));
  assign mem_cmd_o = req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];
  assign fire      = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    req_cmd_ready_o = '0;
    if (fire) req_cmd_ready_o[grant] = 1'b1;
  end

  // Responses come back in issue order, so the tracker head names the owner.
  assign head_id         = tracker_r[head_r];
  assign mem_resp_yumi_o = ~empty & req_resp_yumi_i[head_id];
  assign pop             = mem_resp_yumi_o;
  assign req_resp_o      = {num_req_p{mem_resp_i}};

  always_comb begin
    req_resp_v_o = '0;
    if (!empty) req_resp_v_o[head_id] = mem_resp_v_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r   <= last_reset_lp;
      lock_r   <= 1'b0;
      gnt_id_r <= '0;
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      lock_r <= mem_cmd_v_o & ~mem_cmd_ready_i;
      if (mem_cmd_v_o) gnt_id_r <= grant;
      if (fire) begin
        last_r <= grant;
        tail_r <= tail_r + ptr_t'(1);
      end
      if (pop) head_r <= head_r + ptr_t'(1);
      case ({fire, pop})
        2'b10:   count_r <= count_r + count_t'(1);
        2'b01:   count_r <= count_r - count_t'(1);
        default: count_r <= count_r;
      endcase
      if (empty && mem_resp_v_i) err_r <= 1'b1;
    end
  end

  // NOTE: tracker storage is not reset; head/tail/count qualify every entry that is read.
  always_ff @(posedge clk_i) begin
    if (fire) tracker_r[tail_r] <= grant;
  end

  assign outstanding_o = count_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Self-checking bench for bp_me_mem_cmd_arbiter: vector table, directed corner sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_bp_me_mem_cmd_arbiter;
  localparam int N = 4;
  localparam int W = 600;
  localparam int M = 8;

  logic             clk = 1'b0;
  logic             reset_n_i;
  logic [N*W-1:0]   req_cmd_i;
  logic [N-1:0]     req_cmd_v_i;
  logic [N-1:0]     req_cmd_ready_o;
  logic [N*W-1:0]   req_resp_o;
  logic [N-1:0]     req_resp_v_o;
  logic [N-1:0]     req_resp_yumi_i;
  logic [W-1:0]     mem_cmd_o;
  logic             mem_cmd_v_o;
  logic             mem_cmd_ready_i;
  logic [W-1:0]     mem_resp_i;
  logic             mem_resp_v_i;
  logic             mem_resp_yumi_o;
  logic [3:0]       outstanding_o;
  logic             err_o;

  bp_me_mem_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(M)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_ready_o(req_cmd_ready_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state: last issuer, pinned grant, queue of issued IDs, sticky error.
  int  m_last;
  bit  m_locked;
  int  m_lock_id;
  int  m_q[$];
  bit  m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tag_of(input int i);
    return {8'(i + 1), cyc[23:0]};
  endfunction

  function automatic logic [W-1:0] msg_of(input logic [31:0] t);
    logic [607:0] w;
    w = {19{t}};
    return w[W-1:0];
  endfunction

  task automatic model_reset();
    m_last    = N - 1;
    m_locked  = 1'b0;
    m_lock_id = 0;
    m_q.delete();
    m_err     = 1'b0;
  endtask

  task automatic model_check();
    int         g;
    bit         cv, fire, empty, exp_ym;
    logic [3:0] exp_rdy, exp_rv;
    logic [W-1:0] exp_msg;
    g  = -1;
    cv = 1'b0;
    if (m_locked) g = m_lock_id;
    else
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_cmd_v_i[(m_last + k) % N]) g = (m_last + k) % N;
    if (g >= 0 && m_q.size() < M)
      if (req_cmd_v_i[g]) cv = 1'b1;
    fire    = cv && mem_cmd_ready_i;
    exp_rdy = fire ? 4'(1 << g) : 4'b0;
    empty   = (m_q.size() == 0);
    exp_rv  = 4'b0;
    exp_ym  = 1'b0;
    if (!empty) begin
      exp_rv = mem_resp_v_i ? 4'(1 << m_q[0]) : 4'b0;
      exp_ym = req_resp_yumi_i[m_q[0]];
    end
    check("m_cmd_v", 64'(mem_cmd_v_o), 64'(cv));
    check("m_cmd_ready", 64'(req_cmd_ready_o), 64'(exp_rdy));
    if (cv) begin
      exp_msg = msg_of(tag_of(g));
      check("m_cmd_lo", mem_cmd_o[63:0], exp_msg[63:0]);
      check("m_cmd_hi", mem_cmd_o[W-1:W-64], exp_msg[W-1:W-64]);
    end
    check("m_resp_v", 64'(req_resp_v_o), 64'(exp_rv));
    check("m_resp_yumi", 64'(mem_resp_yumi_o), 64'(exp_ym));
    check("m_outstanding", 64'(outstanding_o), 64'(m_q.size()));
    check("m_err", 64'(err_o), 64'(m_err));
    for (int i = 0; i < N; i++)
      check("m_resp_data", req_resp_o[i*W +: 64], mem_resp_i[63:0]);
    if (exp_ym) void'(m_q.pop_front());
    if (fire) begin
      m_q.push_back(g);
      m_last = g;
    end
    m_locked  = cv && !mem_cmd_ready_i;
    m_lock_id = g;
    if (empty && mem_resp_v_i) m_err = 1'b1;
  endtask

  // Apply one cycle of inputs at the falling edge and check just after.
  task automatic drive(input logic [3:0] v, input logic rdy, input logic rv, input logic [3:0] ym);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) req_cmd_i[i*W +: W] = msg_of(tag_of(i));
    req_cmd_v_i     = v;
    mem_cmd_ready_i = rdy;
    mem_resp_v_i    = rv;
    req_resp_yumi_i = ym;
    mem_resp_i      = msg_of($urandom());
    #1;
    model_check();
  endtask

  task automatic clear_inputs();
    req_cmd_v_i     = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    req_resp_yumi_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n_i = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic       rv;
    logic [3:0] ym;
    logic       exp_cmd_v;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rv;
    logic       exp_ym;
    logic [3:0] exp_out;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic rdy, input logic rv, input logic [3:0] ym,
                              input logic cmd_v, input logic [3:0] er, input logic [3:0] erv,
                              input logic eym, input logic [3:0] eout);
    vec_t r;
    r.v = v; r.rdy = rdy; r.rv = rv; r.ym = ym;
    r.exp_cmd_v = cmd_v; r.exp_rdy = er; r.exp_rv = erv; r.exp_ym = eym; r.exp_out = eout;
    return r;
  endfunction

  vec_t tbl[13];
  int   order[4];

  initial begin
    reset_n_i = 1'b1;
    req_cmd_i = '0;
    mem_resp_i = '0;
    clear_inputs();
    model_reset();

    // Fairness rotation from reset, then fill to full and drain one slot.
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(4'hF, 1, 0, 4'h0, 1, 4'(1 << (i % 4)), 4'h0, 0, 4'(i));
    tbl[8]  = mk(4'hF, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 4'd8);
    tbl[9]  = mk(4'hF, 1, 1, 4'h1, 0, 4'h0, 4'h1, 1, 4'd8);
    tbl[10] = mk(4'hF, 1, 0, 4'h0, 1, 4'h1, 4'h0, 0, 4'd7);
    tbl[11] = mk(4'h0, 1, 1, 4'h2, 0, 4'h0, 4'h2, 1, 4'd8);
    tbl[12] = mk(4'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 4'd7);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].rdy, tbl[i].rv, tbl[i].ym);
      check("tbl_cmd_v", 64'(mem_cmd_v_o), 64'(tbl[i].exp_cmd_v));
      check("tbl_cmd_ready", 64'(req_cmd_ready_o), 64'(tbl[i].exp_rdy));
      check("tbl_resp_v", 64'(req_resp_v_o), 64'(tbl[i].exp_rv));
      check("tbl_resp_yumi", 64'(mem_resp_yumi_o), 64'(tbl[i].exp_ym));
      check("tbl_outstanding", 64'(outstanding_o), 64'(tbl[i].exp_out));
    end

    // Single requester back-to-back, responses routed only to slot 2.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1, 0, 4'h0);
      check("single_ready", 64'(req_cmd_ready_o), 64'h4);
    end
    drive(4'h0, 0, 0, 4'h0);
    check("single_out3", 64'(outstanding_o), 64'd3);
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 0, 1, 4'b0100);
      check("single_resp_v", 64'(req_resp_v_o), 64'h4);
    end
    drive(4'h0, 0, 0, 4'h0);
    check("single_out0", 64'(outstanding_o), 64'd0);

    // Lock holds req 1 through a stall even though req 0 would win the scan.
    do_reset();
    drive(4'b0010, 0, 0, 4'h0);
    check("lock_cmd_v", 64'(mem_cmd_v_o), 64'd1);
    check("lock_data0", 64'(mem_cmd_o[31:0]), 64'(tag_of(1)));
    drive(4'b0011, 0, 0, 4'h0);
    check("lock_data1", 64'(mem_cmd_o[31:0]), 64'(tag_of(1)));
    drive(4'b0011, 0, 0, 4'h0);
    check("lock_data2", 64'(mem_cmd_o[31:0]), 64'(tag_of(1)));
    drive(4'b0011, 1, 0, 4'h0);
    check("lock_fire1", 64'(req_cmd_ready_o), 64'h2);
    drive(4'b0001, 1, 0, 4'h0);
    check("lock_next0", 64'(req_cmd_ready_o), 64'h1);
    // Locked requester drops valid: nothing is issued that cycle.
    drive(4'b0100, 0, 0, 4'h0);
    drive(4'b1000, 1, 0, 4'h0);
    check("drop_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("drop_ready", 64'(req_cmd_ready_o), 64'h0);
    drive(4'b1000, 1, 0, 4'h0);
    check("drop_then3", 64'(req_cmd_ready_o), 64'h8);

    // Response ordering 3,0,3,1 with a non-head yumi ignored.
    do_reset();
    order = '{3, 0, 3, 1};
    for (int i = 0; i < 4; i++) drive(4'(1 << order[i]), 1, 0, 4'h0);
    drive(4'h0, 0, 1, 4'b0010);
    check("order_nonhead_v", 64'(req_resp_v_o), 64'h8);
    check("order_nonhead_yumi", 64'(mem_resp_yumi_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(4'h0, 0, 1, 4'(1 << order[i]));
      check("order_resp_v", 64'(req_resp_v_o), 64'(1 << order[i]));
      check("order_yumi", 64'(mem_resp_yumi_o), 64'd1);
    end
    drive(4'h0, 0, 0, 4'h0);
    check("order_out0", 64'(outstanding_o), 64'd0);

    // Response on empty tracker sets the sticky error.
    drive(4'h0, 0, 1, 4'hF);
    check("err_resp_v", 64'(req_resp_v_o), 64'h0);
    check("err_yumi", 64'(mem_resp_yumi_o), 64'd0);
    drive(4'h0, 0, 0, 4'h0);
    check("err_set", 64'(err_o), 64'd1);
    drive(4'h0, 0, 0, 4'h0);
    check("err_hold", 64'(err_o), 64'd1);

    // Asynchronous reset mid-lock with five outstanding.
    for (int i = 0; i < 5; i++) drive(4'b0001, 1, 0, 4'h0);
    drive(4'b0100, 0, 0, 4'h0);
    check("pre_rst_out", 64'(outstanding_o), 64'd5);
    check("pre_rst_cmd_v", 64'(mem_cmd_v_o), 64'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_err", 64'(err_o), 64'd0);
    check("async_out", 64'(outstanding_o), 64'd0);
    check("async_cmd_v", 64'(mem_cmd_v_o), 64'd0);
    check("async_ready", 64'(req_cmd_ready_o), 64'h0);
    check("async_yumi", 64'(mem_resp_yumi_o), 64'd0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    reset_n_i = 1'b1;

    // Randomized traffic against the reference model, with periodic resets.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 1000; i++)
        drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
